// File: rtl/ysyx_25020037_lsu_pkg.sv
// Shared configuration for the load/store unit: bus widths, funct3 codes
// and FSM state encodings.
package ysyx_25020037_lsu_pkg;

    localparam int EU_TO_LU_BUS_WD = 64;
    localparam int LU_TO_WU_BUS_WD = 32;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes (share encodings with the signed loads)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/ysyx_25020037_lsu_align.sv
// Combinational lane logic: store byte strobes / replicated data, load
// extraction with sign/zero extension, and the misaligned/illegal check.
module ysyx_25020037_lsu_align
    import ysyx_25020037_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] src2,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        bad
);

    logic [31:0] shifted;
    logic        legal;
    logic        misal;

    // Decode funct3 into lane strobes, store data, load value and legality
    always_comb begin
        shifted   = rdata >> {addr, 3'b000};
        wstrb     = 4'b0000;
        wdata     = 32'h0000_0000;
        load_data = 32'h0000_0000;
        legal     = 1'b0;
        misal     = 1'b0;
        case (funct3)
            F3_LB: begin
                legal     = 1'b1;
                wstrb     = 4'b0001 << addr;
                wdata     = {4{src2[7:0]}};
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_LH: begin
                legal     = 1'b1;
                misal     = addr[0];
                wstrb     = 4'b0011 << addr;
                wdata     = {2{src2[15:0]}};
                load_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_LW: begin
                legal     = 1'b1;
                misal     = (addr != 2'b00);
                wstrb     = 4'b1111;
                wdata     = src2;
                load_data = shifted;
            end
            F3_LBU: begin
                legal     = is_load;
                load_data = {24'h00_0000, shifted[7:0]};
            end
            F3_LHU: begin
                legal     = is_load;
                misal     = addr[0];
                load_data = {16'h0000, shifted[15:0]};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        // Both load and store set at once is an illegal encoding
        bad = (is_load | is_store) & ((is_load & is_store) | ~legal | misal);
    end

endmodule

// File: rtl/ysyx_25020037_lsu.sv
// Load/store unit: accepts EXU payloads, issues one word-aligned memory
// request for loads/stores, and hands a 32-bit writeback value to WBU.
module ysyx_25020037_lsu
    import ysyx_25020037_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC     = 1023,
    parameter int          EU_TO_LU_BUS_WD = ysyx_25020037_lsu_pkg::EU_TO_LU_BUS_WD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exu_valid,
    output logic                       lsu_ready,
    input  logic                       inst_l,
    input  logic                       inst_s,
    input  logic [2:0]                 mem_funct3,
    input  logic [EU_TO_LU_BUS_WD-1:0] eu_to_lu_bus,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_wen,
    output logic [31:0]                mem_req_addr,
    output logic [31:0]                mem_req_wdata,
    output logic [3:0]                 mem_req_wstrb,
    input  logic                       mem_resp_valid,
    input  logic [31:0]                mem_resp_rdata,
    input  logic                       mem_resp_err,
    output logic                       lsu_valid,
    input  logic                       wbu_ready,
    output logic [LU_TO_WU_BUS_WD-1:0] lu_to_wu_bus,
    output logic                       lsu_err
);

    localparam logic        TO_EN   = (TIMEOUT_CYC != 32'd0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC) - 32'd1;

    lsu_state_t  state_r, state_s;
    logic [2:0]  funct3_r;
    logic [1:0]  addr_lo_r;
    logic        inst_l_r, inst_s_r;
    logic [31:0] cnt_r, cnt_s;

    logic [31:0] result_s, src2_s;
    logic        accept_s, timeout_s;

    // Align inputs: live payload during IDLE, captured payload afterwards
    logic [2:0]  al_funct3_s;
    logic [1:0]  al_addr_s;
    logic        al_load_s, al_store_s;
    logic [3:0]  al_wstrb_s;
    logic [31:0] al_wdata_s, al_load_data_s;
    logic        al_bad_s;

    // Next values of the registered outputs
    logic        req_valid_s, req_wen_s;
    logic [31:0] req_addr_s, req_wdata_s;
    logic [3:0]  req_wstrb_s;
    logic [31:0] wb_data_s;
    logic        err_s;

    assign result_s  = eu_to_lu_bus[EU_TO_LU_BUS_WD-1 -: 32];
    assign src2_s    = eu_to_lu_bus[31:0];
    assign accept_s  = exu_valid & lsu_ready;
    assign timeout_s = TO_EN & (cnt_r == TO_LAST);

    assign al_funct3_s = (state_r == ST_IDLE) ? mem_funct3     : funct3_r;
    assign al_addr_s   = (state_r == ST_IDLE) ? result_s[1:0]  : addr_lo_r;
    assign al_load_s   = (state_r == ST_IDLE) ? inst_l         : inst_l_r;
    assign al_store_s  = (state_r == ST_IDLE) ? inst_s         : inst_s_r;

    ysyx_25020037_lsu_align u_align (
        .funct3    (al_funct3_s),
        .addr      (al_addr_s),
        .is_load   (al_load_s),
        .is_store  (al_store_s),
        .src2      (src2_s),
        .rdata     (mem_resp_rdata),
        .wstrb     (al_wstrb_s),
        .wdata     (al_wdata_s),
        .load_data (al_load_data_s),
        .bad       (al_bad_s)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output logic; every field holds unless changed
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        req_valid_s = mem_req_valid;
        req_wen_s   = mem_req_wen;
        req_addr_s  = mem_req_addr;
        req_wdata_s = mem_req_wdata;
        req_wstrb_s = mem_req_wstrb;
        wb_data_s   = lu_to_wu_bus;
        err_s       = lsu_err;
        case (state_r)
            ST_IDLE: begin
                if (exu_valid) begin
                    if (!inst_l && !inst_s) begin
                        state_s   = ST_DONE;
                        wb_data_s = result_s;
                        err_s     = 1'b0;
                    end else if (al_bad_s) begin
                        state_s   = ST_DONE;
                        wb_data_s = 32'h0000_0000;
                        err_s     = 1'b1;
                    end else begin
                        state_s     = ST_REQ;
                        req_valid_s = 1'b1;
                        req_wen_s   = inst_s;
                        req_addr_s  = {result_s[31:2], 2'b00};
                        req_wdata_s = inst_s ? al_wdata_s : 32'h0000_0000;
                        req_wstrb_s = inst_s ? al_wstrb_s : 4'b0000;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_s     = ST_WAIT;
                    req_valid_s = 1'b0;
                    cnt_s       = 32'd0;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                cnt_s = cnt_r + 32'd1;
                if (mem_resp_valid) begin
                    state_s   = ST_DONE;
                    err_s     = mem_resp_err;
                    wb_data_s = (inst_l_r && !mem_resp_err) ? al_load_data_s : 32'h0000_0000;
                end else if (timeout_s) begin
                    state_s   = ST_DONE;
                    err_s     = 1'b1;
                    wb_data_s = 32'h0000_0000;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (wbu_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, payload capture and watchdog counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsu_ready     <= 1'b1;
            lsu_valid     <= 1'b0;
            lsu_err       <= 1'b0;
            lu_to_wu_bus  <= 32'h0000_0000;
            mem_req_valid <= 1'b0;
            mem_req_wen   <= 1'b0;
            mem_req_addr  <= 32'h0000_0000;
            mem_req_wdata <= 32'h0000_0000;
            mem_req_wstrb <= 4'b0000;
            cnt_r         <= 32'd0;
            funct3_r      <= 3'b000;
            addr_lo_r     <= 2'b00;
            inst_l_r      <= 1'b0;
            inst_s_r      <= 1'b0;
        end else begin
            lsu_ready     <= (state_s == ST_IDLE);
            lsu_valid     <= (state_s == ST_DONE);
            lsu_err       <= err_s;
            lu_to_wu_bus  <= wb_data_s;
            mem_req_valid <= req_valid_s;
            mem_req_wen   <= req_wen_s;
            mem_req_addr  <= req_addr_s;
            mem_req_wdata <= req_wdata_s;
            mem_req_wstrb <= req_wstrb_s;
            cnt_r         <= cnt_s;
            if (accept_s) begin
                funct3_r  <= mem_funct3;
                addr_lo_r <= result_s[1:0];
                inst_l_r  <= inst_l;
                inst_s_r  <= inst_s;
            end else begin
                funct3_r  <= funct3_r;
                addr_lo_r <= addr_lo_r;
                inst_l_r  <= inst_l_r;
                inst_s_r  <= inst_s_r;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// Self-checking bench for ysyx_25020037_lsu: directed cases from the test
// plan followed by randomized transactions checked against a reference model.
module tb_ysyx_25020037_lsu;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_ready, inst_l, inst_s;
    logic [2:0]  mem_funct3;
    logic [63:0] eu_to_lu_bus;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid, mem_resp_err;
    logic [31:0] mem_resp_rdata;
    logic        lsu_valid, wbu_ready, lsu_err;
    logic [31:0] lu_to_wu_bus;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx_25020037_lsu #(.TIMEOUT_CYC(TO), .EU_TO_LU_BUS_WD(64)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .lsu_ready(lsu_ready),
        .inst_l(inst_l), .inst_s(inst_s), .mem_funct3(mem_funct3),
        .eu_to_lu_bus(eu_to_lu_bus),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .mem_resp_err(mem_resp_err),
        .lsu_valid(lsu_valid), .wbu_ready(wbu_ready),
        .lu_to_wu_bus(lu_to_wu_bus), .lsu_err(lsu_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size from funct3, lane math from byte offsets
    task automatic ref_model(input logic l, input logic s, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] src2,
                             input logic [31:0] rdata, output logic bad,
                             output logic [3:0] strb, output logic [31:0] wdat,
                             output logic [31:0] ld);
        int size;
        int off;
        logic legal;
        logic [31:0] v;
        off = int'(addr % 32'd4);
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        if (l) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        else   legal = (f3 <= 3'd2);
        bad = (l || s) && ((l && s) || !legal || size == 0 || (off % size) != 0);
        strb = 4'b0000;
        for (int i = 0; i < size; i++)
            if (off + i < 4) strb[off + i] = 1'b1;
        if (size == 1)      wdat = 32'(src2[7:0]) * 32'h0101_0101;
        else if (size == 2) wdat = 32'(src2[15:0]) * 32'h0001_0001;
        else                wdat = src2;
        v = rdata >> (8 * off);
        if (size == 1) v = v & 32'h0000_00FF;
        if (size == 2) v = v & 32'h0000_FFFF;
        if (!f3[2] && (size == 1 || size == 2) && v[8 * size - 1])
            v = v - (32'd1 << (8 * size));
        ld = v;
    endtask

    task automatic run_txn(input string tag, input logic l, input logic s,
                           input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] src2, input logic [31:0] rdata,
                           input logic rerr, input int stall, input int lat,
                           input bit no_resp, input int hold);
        logic bad;
        logic [3:0] strb;
        logic [31:0] wdat, ld, exp_data;
        logic exp_err;
        int n;
        ref_model(l, s, f3, addr, src2, rdata, bad, strb, wdat, ld);
        chk({tag, ".ready"}, 32'(lsu_ready), 32'd1);
        exu_valid    = 1'b1;
        inst_l       = l;
        inst_s       = s;
        mem_funct3   = f3;
        eu_to_lu_bus = {addr, src2};
        tick();
        exu_valid    = 1'b0;
        inst_l       = 1'($urandom);
        inst_s       = 1'($urandom);
        mem_funct3   = 3'($urandom);
        eu_to_lu_bus = {$urandom, $urandom};
        if (!(l || s) || bad) begin
            exp_data = (l || s) ? 32'd0 : addr;
            exp_err  = bad;
            chk({tag, ".noreq"}, 32'(mem_req_valid), 32'd0);
        end else begin
            for (int i = 0; i <= stall; i++) begin
                chk({tag, ".reqv"},  32'(mem_req_valid), 32'd1);
                chk({tag, ".addr"},  mem_req_addr, {addr[31:2], 2'b00});
                chk({tag, ".wen"},   32'(mem_req_wen), 32'(s));
                chk({tag, ".wstrb"}, 32'(mem_req_wstrb), s ? 32'(strb) : 32'd0);
                if (s) chk({tag, ".wdata"}, mem_req_wdata, wdat);
                if (i < stall) begin
                    mem_req_ready = 1'b0;
                    tick();
                end
            end
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            chk({tag, ".reqdrop"}, 32'(mem_req_valid), 32'd0);
            if (no_resp) begin
                n = 0;
                while (!lsu_valid && n < 50) begin
                    tick();
                    n++;
                end
                chk({tag, ".towait"}, n, TO);
                exp_err  = 1'b1;
                exp_data = 32'd0;
            end else begin
                for (int i = 0; i < lat; i++) begin
                    chk({tag, ".wait"}, 32'(lsu_valid), 32'd0);
                    tick();
                end
                mem_resp_valid = 1'b1;
                mem_resp_rdata = rdata;
                mem_resp_err   = rerr;
                tick();
                mem_resp_valid = 1'b0;
                mem_resp_err   = 1'b0;
                mem_resp_rdata = $urandom;
                exp_err  = rerr;
                exp_data = (l && !rerr) ? ld : 32'd0;
            end
        end
        for (int i = 0; i <= hold; i++) begin
            chk({tag, ".valid"}, 32'(lsu_valid), 32'd1);
            chk({tag, ".busy"},  32'(lsu_ready), 32'd0);
            chk({tag, ".data"},  lu_to_wu_bus, exp_data);
            chk({tag, ".err"},   32'(lsu_err), 32'(exp_err));
            if (i < hold) tick();
        end
        wbu_ready = 1'b1;
        tick();
        wbu_ready = 1'b0;
        chk({tag, ".vdrop"}, 32'(lsu_valid), 32'd0);
        chk({tag, ".rdy"},   32'(lsu_ready), 32'd1);
    endtask

    initial begin
        logic l, s;
        logic [2:0] f3;
        int kind;
        rst = 1'b1;
        exu_valid = 1'b0; inst_l = 1'b0; inst_s = 1'b0; mem_funct3 = 3'b000;
        eu_to_lu_bus = 64'd0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'd0; mem_resp_err = 1'b0; wbu_ready = 1'b0;
        tick();
        tick();
        chk("rst.ready", 32'(lsu_ready), 32'd1);
        chk("rst.valid", 32'(lsu_valid), 32'd0);
        chk("rst.err",   32'(lsu_err), 32'd0);
        chk("rst.reqv",  32'(mem_req_valid), 32'd0);
        chk("rst.wen",   32'(mem_req_wen), 32'd0);
        chk("rst.wstrb", 32'(mem_req_wstrb), 32'd0);
        chk("rst.addr",  mem_req_addr, 32'd0);
        chk("rst.wdata", mem_req_wdata, 32'd0);
        chk("rst.wb",    lu_to_wu_bus, 32'd0);
        rst = 1'b0;
        tick();

        // Directed cases
        run_txn("alu",   1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 1);
        run_txn("sb",    1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0, 1'b0, 0, 0, 1'b0, 0);
        run_txn("lb",    1'b1, 1'b0, 3'b000, 32'h8000_0002, 32'h0, 32'h00F0_0000, 1'b0, 0, 0, 1'b0, 0);
        run_txn("lbu",   1'b1, 1'b0, 3'b100, 32'h8000_0002, 32'h0, 32'h00F0_0000, 1'b0, 0, 0, 1'b0, 0);
        run_txn("lh",    1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_0000, 1'b0, 0, 2, 1'b0, 0);
        run_txn("lwmis", 1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 0);
        run_txn("shmis", 1'b0, 1'b1, 3'b001, 32'h8000_0001, 32'h1234, 32'h0, 1'b0, 0, 0, 1'b0, 0);
        run_txn("stall", 1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b1, 5, 1, 1'b0, 0);
        run_txn("tmo",   1'b1, 1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 0);
        run_txn("both",  1'b1, 1'b1, 3'b010, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 0);
        run_txn("sw",    1'b0, 1'b1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, 1, 1, 1'b0, 0);
        run_txn("lbuil", 1'b0, 1'b1, 3'b100, 32'h8000_0010, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0, 0);

        // Reset while waiting for a response, then a late response
        exu_valid = 1'b1; inst_l = 1'b1; inst_s = 1'b0; mem_funct3 = 3'b010;
        eu_to_lu_bus = {32'h8000_0020, 32'h0};
        tick();
        exu_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst.reqv",  32'(mem_req_valid), 32'd0);
        chk("arst.ready", 32'(lsu_ready), 32'd1);
        chk("arst.valid", 32'(lsu_valid), 32'd0);
        chk("arst.wb",    lu_to_wu_bus, 32'd0);
        #1 rst = 1'b0;
        tick();
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555_AAAA; mem_resp_err = 1'b1;
        tick();
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        tick();
        chk("late.valid", 32'(lsu_valid), 32'd0);
        chk("late.ready", 32'(lsu_ready), 32'd1);
        chk("late.reqv",  32'(mem_req_valid), 32'd0);
        run_txn("postrst", 1'b1, 1'b0, 3'b101, 32'h8000_0022, 32'h0, 32'h9ABC_1234, 1'b0, 0, 1, 1'b0, 0);

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0)      begin l = 1'b0; s = 1'b0; end
            else if (kind == 1) begin l = 1'b1; s = 1'b1; end
            else if (kind < 6)  begin l = 1'b1; s = 1'b0; end
            else                begin l = 1'b0; s = 1'b1; end
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = {1'b0, 2'($urandom_range(0, 2))};
            run_txn("rnd", l, s, f3, 32'h8000_0000 | ($urandom & 32'h0000_0FFF),
                    $urandom, $urandom, ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'b0,
                    int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
